rpn_issue_ctrl: RTL and testbench
=================================

# rpn_issue_ctrl

Upstream issue controller for the stack-based ALU. It accepts a stream of postfix (RPN) tokens over a valid/ready handshake and buffers them in a small FIFO. It tracks stack depth, issues exactly one push/add/mul/pop opcode per cycle to the ALU, and returns one result beat per expression with overflow and error status. Malformed expressions never reach the ALU as illegal operations; the controller drains the ALU stack itself.

## Interface
- N, 4, operand/result width (matches ALU data width)
- DEPTH, 8, ALU stack capacity in entries
- FIFO_DEPTH, 4, token FIFO entries (power of two)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- tok_valid  in  1  token offered
- tok_ready  out  1  FIFO not full; token accepted when valid&&ready at clk edge
- tok_kind  in  2  00 operand, 01 add, 10 mul, 11 end-of-expression
- tok_data  in  N  operand value (ignored unless kind=00)
- alu_opcode  out  3  110 push, 100 add, 101 mul, 111 pop, 000 no-op
- alu_data  out  N  operand for push
- alu_result  in  N  ALU output_data, valid one cycle after issue
- alu_overflow  in  1  ALU overflow, valid one cycle after add/mul issue
- res_valid  out  1  result beat held until res_ready
- res_ready  in  1  consumer accepts result
- res_data  out  N  popped result (0 on error)
- res_overflow  out  1  any add/mul in expression overflowed
- res_err  out  1  expression malformed (underflow, stack full, bad end depth)
- busy  out  1  state != IDLE or FIFO non-empty

## Operation
- Reset: all outputs 0 (alu_opcode=000, res_*=0, tok_ready=1 once out of reset), depth=0, FIFO empty, state IDLE, sticky flags cleared.
- States: IDLE (issue), WAIT (capture pop result), RESULT (hold beat), DRAIN (pop leftovers after error).
- IDLE, FIFO non-empty: pop one token per cycle, register opcode:
  - operand: depth==DEPTH -> err flag, go DRAIN, no issue; else push, depth+1.
  - add/mul: depth<2 -> err, DRAIN; else issue, depth-1.
  - end: depth!=1 -> err, DRAIN; else issue pop, depth=0, go WAIT.
- IDLE, FIFO empty: alu_opcode=000.
- WAIT: capture alu_result into res_data, go RESULT.
- DRAIN: issue pop per cycle while depth>0; also discard FIFO tokens until an end token is consumed; when both done, res_data=0, res_err=1, go RESULT. If the stream's end token was already the error cause, only the pop drain applies.
- RESULT: res_valid=1; on res_ready, clear sticky flags, return to IDLE.
- Overflow: alu_overflow sampled the cycle after each add/mul issue and ORed into sticky flag; result beat reports it.
- Depth arithmetic is $clog2(DEPTH+1) bits; never wraps (guards above).
- FIFO: pointer wrap modulo FIFO_DEPTH; simultaneous push and pop when full is allowed only if pop occurs (tok_ready stays combinational on full only).

## Timing
- Token accepted at edge e0 is issued (alu_opcode registered) at e1 earliest; ALU executes at e2.
- Back-to-back tokens issue every cycle, no bubbles, in IDLE.
- End token: pop issued at e1, result captured at e3 edge, res_valid high from e3.
- Overflow of final arithmetic is sampled before WAIT captures, so always included.
- res_valid and res_* stable until res_ready handshake; no token is issued during WAIT/RESULT (FIFO still accepts).
- Asynchronous reset mid-expression: immediate return to reset values; the ALU is expected to be reset by the same rst_n.

## Configuration
- RPN_OVF_ABORT_EN defined: an overflow sample forces res_err=1 and entry to DRAIN in the following cycle (no further arithmetic issued for that expression).
- Undefined: overflow is sticky only; evaluation continues and res_overflow reports it with the computed result.

## Test plan
- push 3, push 4, mul, end -> alu opcodes 110,110,101,111 on consecutive cycles; res_data=4'b1100, res_overflow=0, res_err=0.
- push 7, push 1, add, end (ALU flags 7+1 overflow) -> res_data=4'b1000, res_overflow=1; with RPN_OVF_ABORT_EN res_err=1, res_data=0.
- push 5, add, end -> underflow: no add issued, one pop drain, res_err=1, res_data=0, depth=0 after.
- 9 pushes with DEPTH=8 then end -> 9th not issued, 8 pops drain, res_err=1.
- tok_valid every cycle with res_ready low -> FIFO fills, tok_ready=0 after 4 buffered tokens, no token lost when res_ready rises.
- rst_n low mid-expression (depth=2) -> all outputs 0 asynchronously, next expression push 2, push 3, add, end -> res_data=5.

Source files
------------

// File: rtl/rpn_issue_ctrl.sv
// rpn_issue_ctrl: issue controller for the stack-based ALU.
// Buffers RPN tokens in a small FIFO and tracks the ALU stack depth.
// It issues one push/add/mul/pop per cycle and returns one result beat
// per expression, with overflow and error status.
// Optional macro RPN_OVF_ABORT_EN: an overflow aborts the expression and
// drains the ALU stack, reporting an error.
module rpn_issue_ctrl #(
  parameter int N          = 4,
  parameter int DEPTH      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tok_valid,
  output logic         tok_ready,
  input  logic [1:0]   tok_kind,
  input  logic [N-1:0] tok_data,
  output logic [2:0]   alu_opcode,
  output logic [N-1:0] alu_data,
  input  logic [N-1:0] alu_result,
  input  logic         alu_overflow,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [N-1:0] res_data,
  output logic         res_overflow,
  output logic         res_err,
  output logic         busy
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_POP  = 3'b111;

  localparam logic [1:0] K_OPND = 2'b00;
  localparam logic [1:0] K_ADD  = 2'b01;
  localparam logic [1:0] K_MUL  = 2'b10;
  localparam logic [1:0] K_END  = 2'b11;

  typedef enum logic [1:0] {IDLE, WAIT, RESULT, DRAIN} state_t;

  state_t         state, state_next;
  logic [DW-1:0]  depth, depth_next;
  logic [2:0]     opcode_next;
  logic [N-1:0]   data_next;
  logic           wait_phase, wait_phase_next;
  logic           end_seen, end_seen_next;
  logic           arith_exec, arith_exec_next;
  logic           ovf_flag, ovf_flag_next;
  logic           res_valid_next, res_overflow_next, res_err_next;
  logic [N-1:0]   res_data_next;

  logic [N+1:0]   mem [FIFO_DEPTH];
  logic [AW:0]    wr_ptr, rd_ptr;
  logic           fifo_empty, fifo_full, fifo_push, fifo_pop;
  logic [1:0]     head_kind;
  logic [N-1:0]   head_data;
  logic           ovf_sample, abort_now;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign tok_ready  = rst_n && (!fifo_full || fifo_pop);
  assign fifo_push  = tok_valid && tok_ready;
  assign {head_kind, head_data} = mem[rd_ptr[AW-1:0]];
  assign busy       = (state != IDLE) || !fifo_empty;

  // The ALU flags overflow one cycle after it executes an add/mul.
  assign ovf_sample = arith_exec && alu_overflow;
`ifdef RPN_OVF_ABORT_EN
  assign abort_now  = ovf_sample;
`else
  assign abort_now  = 1'b0;
`endif

  // Token storage; payload is not reset, validity comes from the pointers.
  always_ff @(posedge clk) begin
    if (fifo_push) mem[wr_ptr[AW-1:0]] <= {tok_kind, tok_data};
  end

  // FIFO pointers wrap naturally modulo FIFO_DEPTH, with one extra bit for full/empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Controller state and every registered output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      depth        <= '0;
      alu_opcode   <= OP_NOP;
      alu_data     <= '0;
      wait_phase   <= 1'b0;
      end_seen     <= 1'b0;
      arith_exec   <= 1'b0;
      ovf_flag     <= 1'b0;
      res_valid    <= 1'b0;
      res_data     <= '0;
      res_overflow <= 1'b0;
      res_err      <= 1'b0;
    end else begin
      state        <= state_next;
      depth        <= depth_next;
      alu_opcode   <= opcode_next;
      alu_data     <= data_next;
      wait_phase   <= wait_phase_next;
      end_seen     <= end_seen_next;
      arith_exec   <= arith_exec_next;
      ovf_flag     <= ovf_flag_next;
      res_valid    <= res_valid_next;
      res_data     <= res_data_next;
      res_overflow <= res_overflow_next;
      res_err      <= res_err_next;
    end
  end

  // Next-state logic: issue tokens, guard stack depth, drain after errors, and hold the result.
  always_comb begin
    state_next        = state;
    depth_next        = depth;
    opcode_next       = OP_NOP;
    data_next         = '0;
    wait_phase_next   = wait_phase;
    end_seen_next     = end_seen;
    arith_exec_next   = (alu_opcode == OP_ADD) || (alu_opcode == OP_MUL);
    ovf_flag_next     = ovf_flag || ovf_sample;
    res_valid_next    = res_valid;
    res_data_next     = res_data;
    res_overflow_next = res_overflow;
    res_err_next      = res_err;
    fifo_pop          = 1'b0;

    case (state)
      IDLE: begin
        if (abort_now) begin
          state_next    = DRAIN;
          end_seen_next = 1'b0;
        end else if (!fifo_empty) begin
          fifo_pop = 1'b1;
          case (head_kind)
            K_OPND: begin
              if (depth == DW'(DEPTH)) begin
                state_next    = DRAIN;
                end_seen_next = 1'b0;
              end else begin
                opcode_next = OP_PUSH;
                data_next   = head_data;
                depth_next  = depth + DW'(1);
              end
            end
            K_ADD, K_MUL: begin
              if (depth < DW'(2)) begin
                state_next    = DRAIN;
                end_seen_next = 1'b0;
              end else begin
                opcode_next = (head_kind == K_ADD) ? OP_ADD : OP_MUL;
                depth_next  = depth - DW'(1);
              end
            end
            default: begin
              if (depth != DW'(1)) begin
                state_next    = DRAIN;
                end_seen_next = 1'b1;
              end else begin
                opcode_next     = OP_POP;
                depth_next      = '0;
                wait_phase_next = 1'b0;
                state_next      = WAIT;
              end
            end
          endcase
        end
      end

      WAIT: begin
        if (abort_now) begin
          state_next      = DRAIN;
          end_seen_next   = 1'b1;
          wait_phase_next = 1'b0;
        end else if (!wait_phase) begin
          wait_phase_next = 1'b1;
        end else begin
          wait_phase_next   = 1'b0;
          res_valid_next    = 1'b1;
          res_data_next     = alu_result;
          res_overflow_next = ovf_flag || ovf_sample;
          res_err_next      = 1'b0;
          state_next        = RESULT;
        end
      end

      DRAIN: begin
        if (depth != '0) begin
          opcode_next = OP_POP;
          depth_next  = depth - DW'(1);
        end
        if (!end_seen && !fifo_empty) begin
          fifo_pop = 1'b1;
          if (head_kind == K_END) end_seen_next = 1'b1;
        end
        if ((depth == '0) && end_seen) begin
          res_valid_next    = 1'b1;
          res_data_next     = '0;
          res_overflow_next = ovf_flag || ovf_sample;
          res_err_next      = 1'b1;
          state_next        = RESULT;
        end
      end

      default: begin
        if (res_ready) begin
          res_valid_next    = 1'b0;
          res_data_next     = '0;
          res_overflow_next = 1'b0;
          res_err_next      = 1'b0;
          ovf_flag_next     = 1'b0;
          end_seen_next     = 1'b0;
          state_next        = IDLE;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_rpn_issue_ctrl.sv
// tb_rpn_issue_ctrl: directed self-checking bench for rpn_issue_ctrl.
// A small behavioural stack ALU answers the issued opcodes.
// Each scenario task drives tokens and compares the results inline.
module tb_rpn_issue_ctrl;

  localparam int N = 4;
  localparam int DEPTH = 8;
  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_POP  = 3'b111;
  localparam logic [2:0] OP_MUL  = 3'b101;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         tok_valid, tok_ready;
  logic [1:0]   tok_kind;
  logic [N-1:0] tok_data;
  logic [2:0]   alu_opcode;
  logic [N-1:0] alu_data, alu_result;
  logic         alu_overflow;
  logic         res_valid, res_ready, res_overflow, res_err, busy;
  logic [N-1:0] res_data;

  int n_checks = 0;
  int n_fails  = 0;
  int cycle    = 0;

  logic [2:0] op_log [$];
  int         cyc_log [$];

  rpn_issue_ctrl #(.N(N), .DEPTH(DEPTH), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_kind(tok_kind), .tok_data(tok_data),
    .alu_opcode(alu_opcode), .alu_data(alu_data), .alu_result(alu_result), .alu_overflow(alu_overflow),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_overflow(res_overflow), .res_err(res_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Cycle counter used to prove issue slots are consecutive.
  always @(posedge clk) cycle <= cycle + 1;

  // Record every non-idle opcode the controller presents to the ALU.
  always @(negedge clk) begin
    if (rst_n && alu_opcode !== 3'b000) begin
      op_log.push_back(alu_opcode);
      cyc_log.push_back(cycle);
    end
  end

  // Behavioural stack ALU: signed add overflow, unsigned mul overflow, one-cycle result latency.
  logic [N-1:0] alu_stk [0:15];
  int           alu_sp;
  logic         alu_illegal = 1'b0;
  logic [N-1:0] opa, opb;
  logic [N:0]   sum5;
  logic [2*N-1:0] prod8;
  logic         sovf;
  assign opb   = (alu_sp >= 1) ? alu_stk[alu_sp-1] : '0;
  assign opa   = (alu_sp >= 2) ? alu_stk[alu_sp-2] : '0;
  assign sum5  = {1'b0, opa} + {1'b0, opb};
  assign prod8 = {4'h0, opa} * {4'h0, opb};
  assign sovf  = (opa[N-1] == opb[N-1]) && (sum5[N-1] != opa[N-1]);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_sp <= 0;
      alu_result <= '0;
      alu_overflow <= 1'b0;
    end else begin
      alu_overflow <= 1'b0;
      case (alu_opcode)
        3'b000: ;
        3'b110: if (alu_sp >= DEPTH) alu_illegal <= 1'b1;
                else begin alu_stk[alu_sp] <= alu_data; alu_sp <= alu_sp + 1; end
        3'b100: if (alu_sp < 2) alu_illegal <= 1'b1;
                else begin alu_stk[alu_sp-2] <= sum5[N-1:0]; alu_sp <= alu_sp - 1; alu_overflow <= sovf; end
        3'b101: if (alu_sp < 2) alu_illegal <= 1'b1;
                else begin alu_stk[alu_sp-2] <= prod8[N-1:0]; alu_sp <= alu_sp - 1; alu_overflow <= |prod8[2*N-1:N]; end
        3'b111: if (alu_sp < 1) alu_illegal <= 1'b1;
                else begin alu_result <= alu_stk[alu_sp-1]; alu_sp <= alu_sp - 1; end
        default: alu_illegal <= 1'b1;
      endcase
    end
  end

  // Offer one token and hold it until accepted (bounded).
  task automatic send(input logic [1:0] kind, input logic [N-1:0] data);
    int k = 0;
    @(negedge clk);
    tok_valid = 1'b1; tok_kind = kind; tok_data = data;
    while (!tok_ready && k < 100) begin @(negedge clk); k++; end
    if (!tok_ready) begin
      n_checks++; n_fails++;
      $display("[TB] FAIL send_timeout: tok_ready got %b required 1", tok_ready);
    end
    @(posedge clk); #1;
    tok_valid = 1'b0;
  endtask

  // Wait for a result beat, counting negedges from the last token acceptance.
  task automatic wait_result(output int lat);
    lat = 0;
    while (lat < 100) begin
      @(negedge clk); lat++;
      if (res_valid) break;
    end
    n_checks++;
    if (res_valid !== 1'b1) begin
      n_fails++;
      $display("[TB] FAIL result_timeout: res_valid got %b required 1", res_valid);
    end
  endtask

  task automatic ack_result();
    @(negedge clk); res_ready = 1'b1;
    @(posedge clk); #1; res_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_checks++; if (alu_opcode !== 3'b000) begin n_fails++; $display("[TB] FAIL reset_opcode: got %b required 000", alu_opcode); end
    n_checks++; if (res_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_res_valid: got %b required 0", res_valid); end
    n_checks++; if (res_data !== 4'h0) begin n_fails++; $display("[TB] FAIL reset_res_data: got %h required 0", res_data); end
    n_checks++; if (tok_ready !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_tok_ready: got %b required 0", tok_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_busy: got %b required 0", busy); end
    @(negedge clk); rst_n = 1'b1; #1;
    n_checks++; if (tok_ready !== 1'b1) begin n_fails++; $display("[TB] FAIL post_reset_tok_ready: got %b required 1", tok_ready); end
  endtask

  task automatic test_basic_mul();
    int lat;
    op_log.delete(); cyc_log.delete();
    send(2'b00, 4'd3); send(2'b00, 4'd4); send(2'b10, 4'd0); send(2'b11, 4'd0);
    wait_result(lat);
    n_checks++; if (lat !== 4) begin n_fails++; $display("[TB] FAIL mul_latency: got %0d negedges required 4", lat); end
    n_checks++; if (op_log.size() !== 4) begin n_fails++; $display("[TB] FAIL mul_op_count: got %0d required 4", op_log.size()); end
    n_checks++; if (op_log.size() == 4 && (op_log[0] !== OP_PUSH || op_log[1] !== OP_PUSH || op_log[2] !== OP_MUL || op_log[3] !== OP_POP))
      begin n_fails++; $display("[TB] FAIL mul_op_seq: got %b %b %b %b required 110 110 101 111", op_log[0], op_log[1], op_log[2], op_log[3]); end
    n_checks++; if (op_log.size() == 4 && cyc_log[3] - cyc_log[0] !== 3) begin n_fails++; $display("[TB] FAIL mul_back_to_back: span got %0d required 3", cyc_log[3] - cyc_log[0]); end
    n_checks++; if (res_data !== 4'b1100) begin n_fails++; $display("[TB] FAIL mul_res_data: got %b required 1100", res_data); end
    n_checks++; if (res_overflow !== 1'b0) begin n_fails++; $display("[TB] FAIL mul_res_overflow: got %b required 0", res_overflow); end
    n_checks++; if (res_err !== 1'b0) begin n_fails++; $display("[TB] FAIL mul_res_err: got %b required 0", res_err); end
    repeat (2) @(negedge clk);
    n_checks++; if (res_valid !== 1'b1 || res_data !== 4'b1100) begin n_fails++; $display("[TB] FAIL mul_hold: valid %b data %b required 1 1100", res_valid, res_data); end
    ack_result();
    n_checks++; if (res_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL mul_release: res_valid got %b required 0", res_valid); end
  endtask

  task automatic test_overflow();
    int lat;
    send(2'b00, 4'd7); send(2'b00, 4'd1); send(2'b01, 4'd0); send(2'b11, 4'd0);
    wait_result(lat);
    n_checks++; if (res_overflow !== 1'b1) begin n_fails++; $display("[TB] FAIL ovf_flag: got %b required 1", res_overflow); end
`ifdef RPN_OVF_ABORT_EN
    n_checks++; if (res_err !== 1'b1) begin n_fails++; $display("[TB] FAIL ovf_abort_err: got %b required 1", res_err); end
    n_checks++; if (res_data !== 4'b0000) begin n_fails++; $display("[TB] FAIL ovf_abort_data: got %b required 0000", res_data); end
`else
    n_checks++; if (res_err !== 1'b0) begin n_fails++; $display("[TB] FAIL ovf_err: got %b required 0", res_err); end
    n_checks++; if (res_data !== 4'b1000) begin n_fails++; $display("[TB] FAIL ovf_data: got %b required 1000", res_data); end
`endif
    ack_result();
  endtask

  task automatic test_underflow();
    int lat;
    op_log.delete(); cyc_log.delete();
    send(2'b00, 4'd5); send(2'b01, 4'd0); send(2'b11, 4'd0);
    wait_result(lat);
    n_checks++; if (res_err !== 1'b1) begin n_fails++; $display("[TB] FAIL uf_err: got %b required 1", res_err); end
    n_checks++; if (res_data !== 4'h0) begin n_fails++; $display("[TB] FAIL uf_data: got %h required 0", res_data); end
    n_checks++; if (res_overflow !== 1'b0) begin n_fails++; $display("[TB] FAIL uf_ovf_cleared: got %b required 0", res_overflow); end
    n_checks++; if (op_log.size() !== 2 || op_log[0] !== OP_PUSH || op_log[1] !== OP_POP)
      begin n_fails++; $display("[TB] FAIL uf_ops: count %0d required 2 (push then pop)", op_log.size()); end
    n_checks++; if (alu_sp !== 0) begin n_fails++; $display("[TB] FAIL uf_alu_empty: sp got %0d required 0", alu_sp); end
    ack_result();
    send(2'b00, 4'd4); send(2'b11, 4'd0);
    wait_result(lat);
    n_checks++; if (res_data !== 4'd4 || res_err !== 1'b0) begin n_fails++; $display("[TB] FAIL uf_recover: data %h err %b required 4 0", res_data, res_err); end
    ack_result();
  endtask

  task automatic test_stack_full();
    int lat, pushes, pops;
    op_log.delete(); cyc_log.delete();
    for (int i = 1; i <= 9; i++) send(2'b00, 4'(i));
    send(2'b11, 4'd0);
    wait_result(lat);
    pushes = 0; pops = 0;
    foreach (op_log[i]) begin
      if (op_log[i] == OP_PUSH) pushes++;
      if (op_log[i] == OP_POP) pops++;
    end
    n_checks++; if (pushes !== 8) begin n_fails++; $display("[TB] FAIL full_pushes: got %0d required 8", pushes); end
    n_checks++; if (pops !== 8) begin n_fails++; $display("[TB] FAIL full_pops: got %0d required 8", pops); end
    n_checks++; if (res_err !== 1'b1 || res_data !== 4'h0) begin n_fails++; $display("[TB] FAIL full_result: err %b data %h required 1 0", res_err, res_data); end
    n_checks++; if (alu_sp !== 0) begin n_fails++; $display("[TB] FAIL full_alu_empty: sp got %0d required 0", alu_sp); end
    ack_result();
  endtask

  task automatic test_fifo_backpressure();
    int lat;
    send(2'b00, 4'd9); send(2'b11, 4'd0);
    wait_result(lat);
    send(2'b00, 4'd2); send(2'b00, 4'd3); send(2'b10, 4'd0); send(2'b00, 4'd1);
    @(negedge clk);
    tok_valid = 1'b1; tok_kind = 2'b01; tok_data = 4'd0;
    #1;
    n_checks++; if (tok_ready !== 1'b0) begin n_fails++; $display("[TB] FAIL fifo_full_ready: got %b required 0", tok_ready); end
    n_checks++; if (busy !== 1'b1) begin n_fails++; $display("[TB] FAIL fifo_busy: got %b required 1", busy); end
    repeat (2) @(negedge clk);
    n_checks++; if (tok_ready !== 1'b0) begin n_fails++; $display("[TB] FAIL fifo_still_full: got %b required 0", tok_ready); end
    n_checks++; if (res_valid !== 1'b1 || res_data !== 4'd9) begin n_fails++; $display("[TB] FAIL fifo_held_result: valid %b data %h required 1 9", res_valid, res_data); end
    tok_valid = 1'b0;
    ack_result();
    send(2'b01, 4'd0); send(2'b11, 4'd0);
    wait_result(lat);
    n_checks++; if (res_data !== 4'd7 || res_err !== 1'b0) begin n_fails++; $display("[TB] FAIL fifo_no_loss: data %h err %b required 7 0", res_data, res_err); end
    ack_result();
  endtask

  task automatic test_reset_mid();
    int lat;
    send(2'b00, 4'd6); send(2'b00, 4'd7);
    @(posedge clk); #2;
    n_checks++; if (alu_opcode !== OP_PUSH || alu_data !== 4'd7) begin n_fails++; $display("[TB] FAIL mid_pre_reset: op %b data %h required 110 7", alu_opcode, alu_data); end
    rst_n = 1'b0; #1;
    n_checks++; if (alu_opcode !== 3'b000 || alu_data !== 4'h0) begin n_fails++; $display("[TB] FAIL mid_async_alu: op %b data %h required 000 0", alu_opcode, alu_data); end
    n_checks++; if (res_valid !== 1'b0 || res_err !== 1'b0 || res_overflow !== 1'b0 || busy !== 1'b0)
      begin n_fails++; $display("[TB] FAIL mid_async_res: valid %b err %b ovf %b busy %b required 0 0 0 0", res_valid, res_err, res_overflow, busy); end
    @(negedge clk); rst_n = 1'b1;
    send(2'b00, 4'd2); send(2'b00, 4'd3); send(2'b01, 4'd0); send(2'b11, 4'd0);
    wait_result(lat);
    n_checks++; if (res_data !== 4'd5 || res_err !== 1'b0 || res_overflow !== 1'b0)
      begin n_fails++; $display("[TB] FAIL mid_after_reset: data %h err %b ovf %b required 5 0 0", res_data, res_err, res_overflow); end
    ack_result();
  endtask

  initial begin
    rst_n = 1'b0; tok_valid = 1'b0; tok_kind = 2'b00; tok_data = '0; res_ready = 1'b0;
    test_reset();
    test_basic_mul();
    test_overflow();
    test_underflow();
    test_stack_full();
    test_fifo_backpressure();
    test_reset_mid();
    n_checks++; if (alu_illegal !== 1'b0) begin n_fails++; $display("[TB] FAIL alu_illegal_op: got %b required 0", alu_illegal); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
